// File: rtl/ufm_mask_writer.sv
// rtl/ufm_mask_writer.sv - writes one capacity mask byte into the MAX II UFM by driving its serial pins
// Optional read-back verify of the programmed word is built when UFM_VERIFY_EN is defined.
module ufm_mask_writer #(
  parameter logic [15:0] BUSY_TO = 16'hFFFF,
  parameter logic [7:0]  DATA_LO = 8'hFF
) (
  input  logic       C14M,
  input  logic       nRES,
  input  logic       Start,
  input  logic [7:0] WrAddr,
  input  logic [7:0] WrData,
  input  logic       EraseFirst,
  input  logic       UFMBusy,
  input  logic       RTPBusy,
  input  logic       DRDOut,
  output logic       ARCLK,
  output logic       ARDIn,
  output logic       ARShift,
  output logic       DRCLK,
  output logic       DRDIn,
  output logic       DRShift,
  output logic       UFMErase,
  output logic       UFMProgram,
  output logic       Busy,
  output logic       Done,
  output logic       Err
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ERQ, ST_EWAIT, ST_SADDR, ST_SDATA, ST_PRQ, ST_PWAIT,
`ifdef UFM_VERIFY_EN
    ST_VADDR, ST_VLOAD, ST_VDATA,
`endif
    ST_DONE, ST_ERROR
  } state_t;

  state_t      state, nxt;
  logic [15:0] cnt;
  logic        cnt_en;
  logic        req;
  logic [7:0]  addr, data;
  logic        ub_meta, ub, rb_meta, rb;
  logic        ready;
  logic [3:0]  slot;
  logic [15:0] word;

  assign ready = ~ub & ~rb;
  // cnt doubles as the wait timeout and, in shift states, as {slot, phase}
  assign slot  = cnt[4:1];
  assign word  = {data, DATA_LO};

`ifdef UFM_VERIFY_EN
  logic [7:0] rd;
`else
  logic unused_drdout;
  assign unused_drdout = DRDOut;
`endif

  always_ff @(posedge C14M or negedge nRES) begin
    if (!nRES) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      req     <= 1'b0;
      addr    <= '0;
      data    <= '0;
      Err     <= 1'b0;
      ub_meta <= 1'b0;
      ub      <= 1'b0;
      rb_meta <= 1'b0;
      rb      <= 1'b0;
`ifdef UFM_VERIFY_EN
      rd      <= '0;
`endif
    end else begin
      ub_meta <= UFMBusy;
      ub      <= ub_meta;
      rb_meta <= RTPBusy;
      rb      <= rb_meta;
      state   <= nxt;
      cnt     <= (nxt != state) ? 16'd0 : cnt + {15'd0, cnt_en};
      // request goes up on the first ready cycle and stays up until the state is left
      req     <= (nxt == state) && (state == ST_ERQ || state == ST_PRQ) && (req || ready);
      if (state == ST_IDLE && Start) begin
        addr <= WrAddr;
        data <= WrData;
        Err  <= 1'b0;
      end
      if (state == ST_EWAIT && nxt == ST_SADDR)
        addr <= 8'h00;
      if (nxt == ST_ERROR)
        Err <= 1'b1;
`ifdef UFM_VERIFY_EN
      if (state == ST_VDATA && !cnt[0])
        rd <= {rd[6:0], DRDOut};
`endif
    end
  end

  always_comb begin
    nxt        = state;
    cnt_en     = 1'b0;
    ARCLK      = 1'b0;
    ARDIn      = 1'b0;
    ARShift    = 1'b0;
    DRCLK      = 1'b0;
    DRDIn      = 1'b0;
    DRShift    = 1'b0;
    UFMErase   = 1'b0;
    UFMProgram = 1'b0;
    case (state)
      ST_IDLE: if (Start) nxt = EraseFirst ? ST_ERQ : ST_SADDR;
      ST_ERQ, ST_PRQ: begin
        cnt_en     = req | ready;
        UFMErase   = (state == ST_ERQ) & req;
        UFMProgram = (state == ST_PRQ) & req;
        if (req && ub)             nxt = (state == ST_ERQ) ? ST_EWAIT : ST_PWAIT;
        else if (cnt == BUSY_TO)   nxt = ST_ERROR;
      end
      ST_EWAIT, ST_PWAIT: begin
        cnt_en = 1'b1;
        if (!ub) begin
          if (state == ST_EWAIT) nxt = ST_SADDR;
`ifdef UFM_VERIFY_EN
          else                   nxt = ST_VADDR;
`else
          else                   nxt = ST_DONE;
`endif
        end else if (cnt == BUSY_TO) begin
          nxt = ST_ERROR;
        end
      end
      ST_SADDR: begin
        cnt_en  = 1'b1;
        ARShift = 1'b1;
        ARCLK   = cnt[0];
        ARDIn   = slot[3] ? 1'b0 : addr[slot[2:0]];
        if (cnt == 16'd17) nxt = ST_SDATA;
      end
      ST_SDATA: begin
        cnt_en  = 1'b1;
        DRShift = 1'b1;
        DRCLK   = cnt[0];
        DRDIn   = word[~slot];
        if (cnt == 16'd31) nxt = ST_PRQ;
      end
`ifdef UFM_VERIFY_EN
      ST_VADDR: begin
        cnt_en  = 1'b1;
        ARShift = 1'b1;
        ARCLK   = cnt[0];
        ARDIn   = slot[3] ? 1'b0 : addr[slot[2:0]];
        if (cnt == 16'd17) nxt = ST_VLOAD;
      end
      ST_VLOAD: begin
        cnt_en = 1'b1;
        DRCLK  = cnt[0];
        if (cnt == 16'd1) nxt = ST_VDATA;
      end
      ST_VDATA: begin
        cnt_en  = 1'b1;
        DRShift = 1'b1;
        DRCLK   = cnt[0];
        if (cnt == 16'd15) nxt = (rd == data) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE:  nxt = ST_IDLE;
      ST_ERROR: nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  assign Busy = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERROR);
  assign Done = (state == ST_DONE);

endmodule

// File: doc/ufm_mask_writer.md
Name: ufm_mask_writer

Overview:
- Write-side companion to the card's power-up UFM scan, which reads the RAMWorks capacity mask from the MAX II user flash.
- Takes one mask byte and a target slot address. Optionally erases the sector first, then bit-bangs the UFM address and data shift registers and runs a program cycle.
- Replaces software bit-banging of the UFM pins. Sits beside the SDRAM/bus controller and drives the UFM primitive's serial pins.

Parameters:
- BUSY_TO, 16'hFFFF: max C14M cycles to wait for UFM busy to assert after an erase/program request, and separately for it to deassert.
- DATA_LO, 8'hFF: low byte of the 16-bit UFM word. The scan uses only the high byte.

Ports:
- C14M  in  1  14.318 MHz system clock; all logic on posedge.
- nRES  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle request; sampled only in IDLE.
- WrAddr  in  8  UFM word address of the next free slot.
- WrData  in  8  capacity mask byte to store.
- EraseFirst  in  1  sector full: erase, then write to address 0.
- UFMBusy  in  1  UFM busy, asynchronous.
- RTPBusy  in  1  UFM real-time-ISP busy, asynchronous.
- DRDOut  in  1  UFM data register serial out; used only with the verify option.
- ARCLK, ARDIn, ARShift  out  1 each  UFM address register clock, data, shift/load.
- DRCLK, DRDIn, DRShift  out  1 each  UFM data register clock, data, shift/load.
- UFMErase, UFMProgram  out  1 each  UFM erase/program requests.
- Busy  out  1  high from accepted Start until DONE/ERROR.
- Done  out  1  one-cycle pulse on successful completion.
- Err  out  1  sticky error flag; cleared by the next accepted Start.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0.
- Reset mid-operation drops UFMErase/UFMProgram immediately. The flash contents are then undefined.
- Synchronizers: UFMBusy and RTPBusy each pass through 2 flops; the FSM uses only the synced versions (UB, RB).
- "Ready" below means ~UB & ~RB.
- Bit slot: 2 C14M cycles.
  - Phase 0: CLK=0; DIn/Shift set up.
  - Phase 1: CLK=1; DIn/Shift held.
  - The UFM clock therefore runs at 7.16 MHz.
- IDLE: Busy=0. On Start, latch WrAddr/WrData/EraseFirst, clear Err, set Busy next cycle. Go to ERQ if EraseFirst, else SADDR. Start in any other state is ignored.
- ERQ: wait for ready, then assert UFMErase. Hold it until UB=1, then drop it and go to EWAIT. If BUSY_TO cycles pass without UB, go to ERROR.
- EWAIT: wait for UB=0, with BUSY_TO timeout. Then force the latched address to 8'h00 and go to SADDR.
- SADDR: 9 slots with ARShift=1, shifting A0 first through A7, then A8=0. 18 cycles total.
- SDATA: 16 slots with DRShift=1, shifting MSB first: WrData[7]..WrData[0], then DATA_LO[7]..DATA_LO[0]. 32 cycles total.
- After the last slot, all CLKs and shifts return to 0.
- PRQ: same handshake as ERQ, using UFMProgram. Then PWAIT waits for UB=0, with timeout.
- PWAIT exit:
  - Without the option, go to DONE.
  - With the option, go to the verify states.
- DONE: Done=1 for 1 cycle, Busy=0, return to IDLE.
- ERROR: Err=1, Busy=0, UFMErase=UFMProgram=0, return to IDLE.
- Timeout counter: reset on every state change. A count equal to BUSY_TO triggers ERROR.
- An RB rise during a request wait only delays the request; it is not an error.
- Latency, no erase and no verify: SADDR+SDATA = 50 cycles, plus the handshake and the flash program time.

Optional Feature:
- UFM_VERIFY_EN defined: after PWAIT, read the word back.
  - Reshift the same 9 address bits (18 cycles).
  - 1 slot with ARShift=0, DRShift=0 loads the data register.
  - 8 slots with DRShift=1 shift in DRDOut MSB first. Sample DRDOut at phase 0, before the CLK rise.
  - Compare the result with WrData. Match goes to DONE; mismatch goes to ERROR.
- UFM_VERIFY_EN undefined: PWAIT goes directly to DONE. DRDOut is unused; tie it off.

Test Plan:
- No erase: Start, WrAddr=8'h05, WrData=8'h3F, busy model 200 cycles.
  - ARDIn sequence is 1,0,1,0,0,0,0,0,0 on ARCLK rises.
  - DRDIn sequence is 0,0,1,1,1,1,1,1 then eight 1s.
  - One UFMProgram pulse held until synced busy; Done pulses once; Err=0.
- Erase: EraseFirst=1, WrAddr=8'hFF, WrData=8'h80.
  - UFMErase completes before any ARCLK activity.
  - Shifted address is all 0; DR shifts 0x80FF; Done pulses.
- Busy never asserts: UFMBusy stuck 0, BUSY_TO=16 -> Err=1 exactly 16 cycles after UFMProgram rises; UFMProgram=0; Busy=0.
- Start while Busy -> ignored. Latched address/data are unchanged and only one Done pulse occurs.
- nRES asserted during SDATA -> outputs 0 asynchronously. After release, a fresh Start completes normally.
- UFM_VERIFY_EN with DRDOut model returning 0x3E for expected 0x3F -> Err=1, no Done. With model returning 0x3F -> Done.
